// File: rtl/mdu_if.sv
// mdu_if: EX-stage <-> multiply/divide sequencer signal bundle.
//
// Signals
//   ex_hold_i       EX is held by some other cause (never by the MDU itself)
//   ex_valid_i      EX holds a valid instruction
//   ex_mdu_i        EX instruction is an MDU op
//   op_i[1:0]       00=MULT 01=MULTU 10=DIV 11=DIVU
//   src_a_i[31:0]   rs operand / dividend
//   src_b_i[31:0]   rt operand / divisor
//   stallreq_for_ex MDU asks the stall controller to hold IF/ID/EX
//   hilo_we         one-cycle HI/LO write strobe
//   hi_o, lo_o      HI/LO result words
//   busy_o          sequencer is not idle
//
// Modports: slave = the sequencer, master = the EX-stage driver.
interface mdu_if;
  logic        ex_hold_i;
  logic        ex_valid_i;
  logic        ex_mdu_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        stallreq_for_ex;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;

  modport slave (
    input  ex_hold_i, ex_valid_i, ex_mdu_i, op_i, src_a_i, src_b_i,
    output stallreq_for_ex, hilo_we, hi_o, lo_o, busy_o
  );

  modport master (
    output ex_hold_i, ex_valid_i, ex_mdu_i, op_i, src_a_i, src_b_i,
    input  stallreq_for_ex, hilo_we, hi_o, lo_o, busy_o
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: multiply/divide sequencer for the EX stage.
//
// Runs MULT/MULTU with a latency of MUL_CYCLES (1..8) and DIV/DIVU as a
// 32-step restoring divide on operand magnitudes. Holds the pipeline through
// stallreq_for_ex while working and issues a single HI/LO write on completion.
//
// Ports
//   clk    clock
//   rst    synchronous active-high reset (aborts and clears results)
//   flush  pipeline flush: abort without writing results
//   mdu    mdu_if.slave bundle (EX request, operands, stall, HI/LO results)
//
// Parameter
//   MUL_CYCLES  multiply latency in cycles, 1..8
//
// Build option
//   MDU_DIV_EARLY_EXIT_EN  when defined, a divide with |dividend| < |divisor|
//                          (divisor non-zero) completes one cycle after accept
//                          with q=0, r=dividend.
module mdu_seq #(
  parameter int MUL_CYCLES = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  mdu_if.slave  mdu
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;          // op is the signed variant
  logic [31:0] a_q, a_d;              // mul: raw rs; div: dividend magnitude shifting into quotient
  logic [31:0] b_q, b_d;              // mul: raw rt; div: divisor magnitude
  logic [31:0] rem_q, rem_d;          // divide partial remainder
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, lo_q;
  logic        we_q;

  logic        accept_s;
  logic        sgn_in_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic [31:0] mul_a_s, mul_b_s;
  logic        mul_sgn_s;
  logic [63:0] prod_s;
  logic [32:0] rem_sh_s, diff_s;
  logic        qbit_s;
  logic [31:0] rem_nx_s, quo_nx_s, quo_fix_s, rem_fix_s;
  logic [31:0] res_hi_s, res_lo_s;
  logic        load_s;
`ifdef MDU_DIV_EARLY_EXIT_EN
  logic        early_s;
`endif

  assign accept_s = (state_q == S_IDLE) && mdu.ex_valid_i && mdu.ex_mdu_i && !flush;
  assign sgn_in_s = ~mdu.op_i[0];
  assign mag_a_s  = (sgn_in_s && mdu.src_a_i[31]) ? (32'd0 - mdu.src_a_i) : mdu.src_a_i;
  assign mag_b_s  = (sgn_in_s && mdu.src_b_i[31]) ? (32'd0 - mdu.src_b_i) : mdu.src_b_i;

`ifdef MDU_DIV_EARLY_EXIT_EN
  // Divide by zero never short-circuits: it needs the all-ones quotient.
  assign early_s = (mag_a_s < mag_b_s) && (mdu.src_b_i != 32'd0);
`endif

  // In IDLE the product is formed from live inputs so MUL_CYCLES=1 can finish
  // straight from accept; afterwards it uses the latched operands.
  assign mul_a_s   = (state_q == S_IDLE) ? mdu.src_a_i : a_q;
  assign mul_b_s   = (state_q == S_IDLE) ? mdu.src_b_i : b_q;
  assign mul_sgn_s = (state_q == S_IDLE) ? sgn_in_s : sgn_q;
  // A 64x64 product truncated to 64 bits is exact for sign/zero-extended
  // 32-bit operands, so one multiplier covers both MULT and MULTU.
  assign prod_s = {{32{mul_sgn_s & mul_a_s[31]}}, mul_a_s} *
                  {{32{mul_sgn_s & mul_b_s[31]}}, mul_b_s};

  // One restoring step: shift in the next dividend bit, try to subtract.
  assign rem_sh_s  = {rem_q, a_q[31]};
  assign diff_s    = rem_sh_s - {1'b0, b_q};
  assign qbit_s    = ~diff_s[32];
  assign rem_nx_s  = qbit_s ? diff_s[31:0] : rem_sh_s[31:0];
  assign quo_nx_s  = {a_q[30:0], qbit_s};
  assign quo_fix_s = neg_quo_q ? (32'd0 - quo_nx_s) : quo_nx_s;
  assign rem_fix_s = neg_rem_q ? (32'd0 - rem_nx_s) : rem_nx_s;

  // Next-state, operand capture, divide iteration and result selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_hi_s  = 32'd0;
    res_lo_s  = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          sgn_d     = sgn_in_s;
          rem_d     = 32'd0;
          neg_quo_d = sgn_in_s & (mdu.src_a_i[31] ^ mdu.src_b_i[31]);
          neg_rem_d = sgn_in_s & mdu.src_a_i[31];
          if (mdu.op_i[1]) begin
            a_d   = mag_a_s;
            b_d   = mag_b_s;
            cnt_d = 5'd0;
`ifdef MDU_DIV_EARLY_EXIT_EN
            if (early_s) begin
              state_d  = S_DONE;
              res_hi_s = mdu.src_a_i;
              res_lo_s = 32'd0;
            end else begin
              state_d = S_DIV;
            end
`else
            state_d = S_DIV;
`endif
          end else begin
            a_d      = mdu.src_a_i;
            b_d      = mdu.src_b_i;
            cnt_d    = 5'd1;
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
            if (MUL_CYCLES == 1) begin
              state_d = S_DONE;
            end else begin
              state_d = S_MUL;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        res_hi_s = prod_s[63:32];
        res_lo_s = prod_s[31:0];
        if (cnt_q == 5'(MUL_CYCLES - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DIV: begin
        a_d      = quo_nx_s;
        rem_d    = rem_nx_s;
        res_hi_s = rem_fix_s;
        res_lo_s = quo_fix_s;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DONE: begin
        if (mdu.ex_hold_i) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Flush wins over every transition, including leaving DONE.
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Results load only on the edge that enters DONE; a flushed op never gets here.
  assign load_s = (state_d == S_DONE) && (state_q != S_DONE);

  // State, datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      sgn_q     <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rem_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      we_q      <= load_s;
      if (load_s) begin
        hi_q <= res_hi_s;
        lo_q <= res_lo_s;
      end else begin
        hi_q <= hi_q;
        lo_q <= lo_q;
      end
    end
  end

  // The accept term is combinational so the op stalls in its own EX cycle;
  // DONE drops the request so the pipeline moves past the instruction.
  assign mdu.stallreq_for_ex = accept_s || (state_q == S_MUL) || (state_q == S_DIV);
  assign mdu.hilo_we         = we_q;
  assign mdu.hi_o            = hi_q;
  assign mdu.lo_o            = lo_q;
  assign mdu.busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq (MUL_CYCLES=2).
module tb_mdu_seq;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef MDU_DIV_EARLY_EXIT_EN
  localparam int EE_LAT = 1;
`else
  localparam int EE_LAT = 33;
`endif

  mdu_if m ();

  mdu_seq #(.MUL_CYCLES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .mdu   (m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drop the request and scramble operands so any late sampling shows up.
  task automatic idle_inputs();
    m.ex_valid_i = 1'b0;
    m.ex_mdu_i   = 1'b0;
    m.op_i       = 2'b00;
    m.src_a_i    = 32'hDEAD_BEEF;
    m.src_b_i    = 32'h1234_5678;
  endtask

  // Present an op in cycle T; it must be accepted (stall) right away.
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    m.ex_valid_i = 1'b1;
    m.ex_mdu_i   = 1'b1;
    m.op_i       = op;
    m.src_a_i    = a;
    m.src_b_i    = b;
    #1;
    chk({tag, "_acc_stall"}, 64'(m.stallreq_for_ex), 64'd1);
  endtask

  // Wait for hilo_we (bounded), checking latency, stall window and results.
  task automatic run(input string tag, input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int   lat;
    logic stall_ok;
    lat      = -1;
    stall_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) idle_inputs();
      #1;
      if (m.hilo_we === 1'b1) begin
        lat = k;
        break;
      end
      if (m.stallreq_for_ex !== 1'b1) stall_ok = 1'b0;
    end
    chk({tag, "_lat"},       64'(lat), 64'(exp_lat));
    chk({tag, "_stallwin"},  64'(stall_ok), 64'd1);
    chk({tag, "_done_stall"}, 64'(m.stallreq_for_ex), 64'd0);
    chk({tag, "_done_busy"}, 64'(m.busy_o), 64'd1);
    chk({tag, "_hi"},        64'(m.hi_o), 64'(exp_hi));
    chk({tag, "_lo"},        64'(m.lo_o), 64'(exp_lo));
  endtask

  // Cycle after DONE with no hold: back in IDLE, strobe gone, results held.
  task automatic after_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    #1;
    chk({tag, "_we_pulse"}, 64'(m.hilo_we), 64'd0);
    chk({tag, "_idle"},     64'(m.busy_o), 64'd0);
    chk({tag, "_hold_res"}, {m.hi_o, m.lo_o}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic seen_we;
    rst         = 1'b1;
    flush       = 1'b0;
    m.ex_hold_i = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 64'(m.stallreq_for_ex), 64'd0);
    chk("rst_we",    64'(m.hilo_we), 64'd0);
    chk("rst_hilo",  {m.hi_o, m.lo_o}, 64'd0);
    chk("rst_busy",  64'(m.busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // DIVU 100/7 = 14 r 2
    issue("divu100_7", 2'b11, 32'd100, 32'd7);
    run("divu100_7", 33, 32'd2, 32'd14);
    after_done("divu100_7", 32'd2, 32'd14);

    // DIV -7/2 = -3 r -1
    issue("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run("div_m7_2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIV INT_MIN / -1
    issue("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run("div_ovf", 33, 32'h0000_0000, 32'h8000_0000);

    // MULT -2*3 = -6
    issue("mult", 2'b00, 32'hFFFF_FFFE, 32'd3);
    run("mult", 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    after_done("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // MULTU 0xFFFFFFFE*3 = 0x2_FFFFFFFA
    issue("multu", 2'b01, 32'hFFFF_FFFE, 32'd3);
    run("multu", 2, 32'h0000_0002, 32'hFFFF_FFFA);

    // Flush at T+10 of a divide: back to IDLE, no write, results untouched
    issue("flush", 2'b10, 32'd1000, 32'd3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) idle_inputs();
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_idle", 64'(m.busy_o), 64'd0);
    chk("flush_hilo", {m.hi_o, m.lo_o}, {32'h0000_0002, 32'hFFFF_FFFA});
    seen_we = m.hilo_we;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      seen_we = seen_we | m.hilo_we;
    end
    chk("flush_no_we", 64'(seen_we), 64'd0);

    // Small-dividend divides (short path when early exit is built in)
    issue("divu5_9", 2'b11, 32'd5, 32'd9);
    run("divu5_9", EE_LAT, 32'd5, 32'd0);
    issue("div_m3_7", 2'b10, 32'hFFFF_FFFD, 32'd7);
    run("div_m3_7", EE_LAT, 32'hFFFF_FFFD, 32'd0);

    // Divide by zero always takes the full path
    issue("divu5_0", 2'b11, 32'd5, 32'd0);
    run("divu5_0", 33, 32'd5, 32'hFFFF_FFFF);

    // DONE held for 3 cycles with the same op still in EX, then back-to-back MULTU
    issue("hold", 2'b11, 32'd100, 32'd7);
    run("hold", 33, 32'd2, 32'd14);
    m.ex_hold_i  = 1'b1;
    m.ex_valid_i = 1'b1;
    m.ex_mdu_i   = 1'b1;
    m.op_i       = 2'b11;
    m.src_a_i    = 32'd100;
    m.src_b_i    = 32'd7;
    seen_we      = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      seen_we = seen_we | m.hilo_we | m.stallreq_for_ex | ~m.busy_o;
    end
    chk("hold_in_done", 64'(seen_we), 64'd0);
    chk("hold_res", {m.hi_o, m.lo_o}, {32'd2, 32'd14});
    m.ex_hold_i = 1'b0;
    @(negedge clk);
    m.op_i    = 2'b01;
    m.src_a_i = 32'hFFFF_FFFE;
    m.src_b_i = 32'd3;
    #1;
    chk("b2b_idle", 64'(m.busy_o), 64'd0);
    chk("b2b_acc",  64'(m.stallreq_for_ex), 64'd1);
    run("b2b_multu", 2, 32'h0000_0002, 32'hFFFF_FFFA);

    // Reset mid-divide: IDLE and cleared results
    issue("rstmid", 2'b11, 32'd100, 32'd7);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) idle_inputs();
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_idle", 64'(m.busy_o), 64'd0);
    chk("rstmid_we",   64'(m.hilo_we), 64'd0);
    chk("rstmid_hilo", {m.hi_o, m.lo_o}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
